pipe_writeback_line: RTL

- Parametrised successor to the fixed two-deep chains of single-bit and 5-bit rising-edge buffers that delay the write address, write enable and result to the register bank.
- Carries a write-back bundle (data, write address, write enable) through DEPTH pipeline stages with valid tracking, stall, flush and occupancy.
- Scoreboards the in-flight writes so the decode stage can detect RAW hazards on two read ports and forward the youngest in-flight result.
- Sits between execute/memory and the register bank, replacing the hand-built buffer chains.

---
 rtl/pipe_writeback_line_if.sv | 38 +++
 rtl/pipe_writeback_line.sv | 88 ++++++++
 2 files changed

// File: rtl/pipe_writeback_line_if.sv
// Write-back pipeline bus: capture bundle, control, decode read ports and observed results.
interface pipe_writeback_line_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 5
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_wa;
  logic             in_we;
  logic             stall;
  logic             flush;
  logic [AW-1:0]    ra_a;
  logic [AW-1:0]    ra_b;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_wa;
  logic             out_we;
  logic             hazard_a;
  logic             hazard_b;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [OCC_W-1:0] occupancy;

  // Upstream/decode side: drives the bundle and read addresses, observes results.
  modport master (
    output in_valid, in_data, in_wa, in_we, stall, flush, ra_a, ra_b,
    input  out_valid, out_data, out_wa, out_we, hazard_a, hazard_b, fwd_a, fwd_b, occupancy
  );

  // Pipeline side.
  modport slave (
    input  in_valid, in_data, in_wa, in_we, stall, flush, ra_a, ra_b,
    output out_valid, out_data, out_wa, out_we, hazard_a, hazard_b, fwd_a, fwd_b, occupancy
  );
endinterface

// File: rtl/pipe_writeback_line.sv
// DEPTH-stage write-back delay line with stall/flush, occupancy and a RAW
// scoreboard that forwards the youngest in-flight result to two read ports.
module pipe_writeback_line #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned AW              = 5,
  parameter bit          ZERO_REG_IGNORE = 1'b1
) (
  input  logic                  clk_pl,
  input  logic                  rst_n_pl,
  pipe_writeback_line_if.slave  bus
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    wa;
    logic             we;
  } stage_t;

  stage_t stage_q [DEPTH];
  stage_t stage_d [DEPTH];

  logic             hit_a, hit_b;
  logic [WIDTH-1:0] fwd_a_v, fwd_b_v;
  logic [OCC_W-1:0] occ;

  // A stage supplies a read port only when it holds a real, enabled write to that address.
  function automatic logic stage_match(stage_t s, logic [AW-1:0] ra);
    return s.valid && s.we && (s.wa == ra) && !(ZERO_REG_IGNORE && (ra == '0));
  endfunction

  // Next-state: flush clears everything, stall holds, otherwise shift toward the oldest stage.
  always_comb begin
    stage_d = stage_q;
    if (bus.flush) begin
      for (int k = 0; k < int'(DEPTH); k++) stage_d[k] = '0;
    end else if (!bus.stall) begin
      stage_d[0] = '{valid: bus.in_valid, data: bus.in_data, wa: bus.in_wa, we: bus.in_we};
      for (int k = 1; k < int'(DEPTH); k++) stage_d[k] = stage_q[k-1];
    end
  end

  // Stage registers.
  always_ff @(posedge clk_pl or negedge rst_n_pl) begin
    if (!rst_n_pl) begin
      for (int k = 0; k < int'(DEPTH); k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) stage_q[k] <= stage_d[k];
    end
  end

  // Scoreboard: scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    fwd_a_v = '0;
    fwd_b_v = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (stage_match(stage_q[k], bus.ra_a)) begin
        hit_a   = 1'b1;
        fwd_a_v = stage_q[k].data;
      end
      if (stage_match(stage_q[k], bus.ra_b)) begin
        hit_b   = 1'b1;
        fwd_b_v = stage_q[k].data;
      end
    end
  end

  // Occupancy: popcount of the stage valid bits.
  always_comb begin
    occ = '0;
    for (int k = 0; k < int'(DEPTH); k++) occ = occ + OCC_W'(stage_q[k].valid);
  end

  // Bank write port comes straight from the oldest stage; bubbles never write.
  assign bus.out_valid = stage_q[DEPTH-1].valid;
  assign bus.out_data  = stage_q[DEPTH-1].data;
  assign bus.out_wa    = stage_q[DEPTH-1].wa;
  assign bus.out_we    = stage_q[DEPTH-1].we & stage_q[DEPTH-1].valid;
  assign bus.hazard_a  = hit_a;
  assign bus.hazard_b  = hit_b;
  assign bus.fwd_a     = fwd_a_v;
  assign bus.fwd_b     = fwd_b_v;
  assign bus.occupancy = occ;
endmodule
